// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory access controller.
// Holds the controller state encoding used by the top and the bench.
package dmem_pkg;

  localparam int AW_DEFAULT           = 16;
  localparam int DW_DEFAULT           = 16;
  localparam int STARVE_LIMIT_DEFAULT = 8;
  localparam int CW_DEFAULT           = 4;

  typedef enum logic [2:0] {
    IDLE,
    P_ACC,
    P_WB,
    P_CAP,
    P_DONE,
    D_ACC,
    D_CAP
  } dmem_state_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// IDLE-time winner selection between pipeline and debug, plus the counter
// that forces a debug grant after a run of pipeline grants.
module dmem_arb_starve
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CW           = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          idle,
  input  logic          pipe_req,
  input  logic          dbg_req,
  output logic          grant_pipe,
  output logic          grant_dbg,
  output logic [CW-1:0] starve_cnt
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;

  // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
  always_comb begin
    grant_dbg    = idle & dbg_req & (~pipe_req | (starve_cnt_q == LIMIT));
    grant_pipe   = idle & pipe_req & ~grant_dbg;
    starve_cnt_d = starve_cnt_q;
    if (grant_dbg) begin
      starve_cnt_d = '0;
    end else if (grant_pipe && dbg_req && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences pipeline and debug accesses onto a single-port synchronous data
// memory; a pipeline access with writeback takes two back-to-back memory cycles.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CW           = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_req,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          pipe_wb_en,
  input  logic [AW-1:0] pipe_wb_addr,
  output logic          pipe_stall,
  output logic          pipe_done,
  output logic [DW-1:0] pipe_rdata,
  output logic [DW-1:0] pipe_wb_data,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  dmem_state_t   state_q, state_d;
  logic          p_we_q, p_we_d;
  logic [AW-1:0] p_addr_q, p_addr_d;
  logic [DW-1:0] p_wdata_q, p_wdata_d;
  logic          p_wb_en_q, p_wb_en_d;
  logic [AW-1:0] p_wb_addr_q, p_wb_addr_d;
  logic          d_we_q, d_we_d;
  logic [AW-1:0] d_addr_q, d_addr_d;
  logic [DW-1:0] d_wdata_q, d_wdata_d;
  logic [DW-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DW-1:0] pipe_wb_data_q, pipe_wb_data_d;

  logic          grant_pipe;
  logic          grant_dbg;
  logic [CW-1:0] starve_cnt;

  dmem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .idle       (state_q == IDLE),
    .pipe_req   (pipe_req),
    .dbg_req    (dbg_req),
    .grant_pipe (grant_pipe),
    .grant_dbg  (grant_dbg),
    .starve_cnt (starve_cnt)
  );

  always_comb begin
    state_d        = state_q;
    p_we_d         = p_we_q;
    p_addr_d       = p_addr_q;
    p_wdata_d      = p_wdata_q;
    p_wb_en_d      = p_wb_en_q;
    p_wb_addr_d    = p_wb_addr_q;
    d_we_d         = d_we_q;
    d_addr_d       = d_addr_q;
    d_wdata_d      = d_wdata_q;
    pipe_rdata_d   = pipe_rdata_q;
    pipe_wb_data_d = pipe_wb_data_q;
    case (state_q)
      IDLE: begin
        if (grant_pipe) begin
          state_d     = P_ACC;
          p_we_d      = pipe_we;
          p_addr_d    = pipe_addr;
          p_wdata_d   = pipe_wdata;
          p_wb_en_d   = pipe_wb_en;
          p_wb_addr_d = pipe_wb_addr;
        end else if (grant_dbg) begin
          state_d   = D_ACC;
          d_we_d    = dbg_we;
          d_addr_d  = dbg_addr;
          d_wdata_d = dbg_wdata;
        end
      end
      P_ACC: state_d = p_wb_en_q ? P_WB : P_CAP;
      P_WB: begin
        // Primary load data returns during the writeback read cycle.
        state_d = P_CAP;
        if (!p_we_q) pipe_rdata_d = mem_rdata;
      end
      P_CAP: begin
        state_d = P_DONE;
        if (!p_wb_en_q && !p_we_q) pipe_rdata_d = mem_rdata;
        if (p_wb_en_q) pipe_wb_data_d = mem_rdata;
      end
      P_DONE:  state_d = IDLE;
      D_ACC:   state_d = D_CAP;
      D_CAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches are reset too, so the bus never sees stale addresses after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      p_we_q         <= 1'b0;
      p_addr_q       <= '0;
      p_wdata_q      <= '0;
      p_wb_en_q      <= 1'b0;
      p_wb_addr_q    <= '0;
      d_we_q         <= 1'b0;
      d_addr_q       <= '0;
      d_wdata_q      <= '0;
      pipe_rdata_q   <= '0;
      pipe_wb_data_q <= '0;
    end else begin
      state_q        <= state_d;
      p_we_q         <= p_we_d;
      p_addr_q       <= p_addr_d;
      p_wdata_q      <= p_wdata_d;
      p_wb_en_q      <= p_wb_en_d;
      p_wb_addr_q    <= p_wb_addr_d;
      d_we_q         <= d_we_d;
      d_addr_q       <= d_addr_d;
      d_wdata_q      <= d_wdata_d;
      pipe_rdata_q   <= pipe_rdata_d;
      pipe_wb_data_q <= pipe_wb_data_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      P_ACC: begin
        mem_en    = 1'b1;
        mem_we    = p_we_q;
        mem_addr  = p_addr_q;
        mem_wdata = p_wdata_q;
      end
      P_WB: begin
        mem_en   = 1'b1;
        mem_addr = p_wb_addr_q;
      end
      D_ACC: begin
        mem_en    = 1'b1;
        mem_we    = d_we_q;
        mem_addr  = d_addr_q;
        mem_wdata = d_wdata_q;
      end
      default: ;
    endcase
  end

  assign pipe_done    = (state_q == P_DONE);
  assign pipe_stall   = pipe_req & ~pipe_done;
  assign pipe_rdata   = pipe_rdata_q;
  assign pipe_wb_data = pipe_wb_data_q;
  assign dbg_gnt      = (state_q == D_ACC);
  assign dbg_rvalid   = (state_q == D_CAP) & ~d_we_q;
  assign dbg_rdata    = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences all accesses to the single-port synchronous data memory (16-bit words, 1-cycle read latency).
- Arbitrates that memory between two requesters:
  - the pipeline MEM stage: load/store, with optional base-register writeback read;
  - the debug/loader port.
- Splits a pipeline access with writeback into two back-to-back memory cycles.
- Stalls the pipeline until the whole access is complete.

Parameters:
- AW, 16, memory address width.
- DW, 16, memory data width.
- STARVE_LIMIT, 8, consecutive pipeline grants made while dbg_req is pending, after which debug wins.
- CW, 4, width of the starvation counter; must satisfy 2^CW > STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pipe_req  in  1  pipeline access request, held high until pipe_done.
- pipe_we  in  1  1 = store, 0 = load.
- pipe_addr  in  AW  primary (rd) address.
- pipe_wdata  in  DW  store data.
- pipe_wb_en  in  1  base writeback required.
- pipe_wb_addr  in  AW  writeback read address (pre- or post-indexed, computed upstream).
- pipe_stall  out  1  = pipe_req & ~pipe_done.
- pipe_done  out  1  one-cycle completion pulse.
- pipe_rdata  out  DW  primary load data.
- pipe_wb_data  out  DW  writeback data.
- dbg_req  in  1  debug request, held until dbg_gnt.
- dbg_we  in  1  debug write.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  one-cycle pulse; the access is on the bus this cycle.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid.
- dbg_rdata  out  DW  debug read data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read access.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; starve_cnt = 0.
  - Request latches, pipe_rdata and pipe_wb_data = 0.
  - All outputs are 0.
  - Reset asserted mid-access abandons the access: no pipe_done, no dbg_rvalid. A write already on the bus still completes in memory.
- States: IDLE, P_ACC, P_WB, P_CAP, P_DONE, D_ACC, D_CAP.
- Requests are sampled only in IDLE. At grant, addr/we/wdata/wb_en/wb_addr of the winner are latched. Later input changes are ignored until completion.
- Arbitration in IDLE:
  - Only pipe_req: pipeline wins.
  - Only dbg_req: debug wins.
  - Both high: pipeline wins unless starve_cnt == STARVE_LIMIT, in which case debug wins.
  - Neither: stay in IDLE.
- starve_cnt:
  - +1 on each pipeline grant made while dbg_req = 1; saturates at STARVE_LIMIT.
  - Cleared on every debug grant.
  - Unchanged otherwise.
- mem_* outputs are a combinational decode of state and latches:
  - P_ACC: en = 1, we = latched we, addr = latched addr, wdata = latched wdata.
  - P_WB: en = 1, we = 0, addr = latched wb_addr.
  - D_ACC: en = 1, we = latched dbg_we, addr and wdata from the debug latches.
  - All other states: en = 0, we = 0, addr = 0, wdata = 0.
- Pipeline transitions:
  - IDLE → P_ACC.
  - P_ACC → P_WB if wb_en, else P_CAP.
  - P_WB → P_CAP.
  - P_CAP → P_DONE.
  - P_DONE → IDLE.
- Pipeline data capture:
  - pipe_rdata is loaded from mem_rdata at the end of the cycle after P_ACC (P_WB or P_CAP). Loaded only when latched we = 0; otherwise it holds its value.
  - pipe_wb_data is loaded from mem_rdata at the end of P_CAP only when wb_en = 1; otherwise it holds its value.
  - pipe_done = 1 exactly in P_DONE.
- Pipeline latency, from the request seen in IDLE at cycle T:
  - No writeback: pipe_done at T+3.
  - With writeback: pipe_done at T+4.
- Debug transitions:
  - IDLE → D_ACC (dbg_gnt = 1).
  - D_ACC → D_CAP (dbg_rvalid = ~latched dbg_we; dbg_rdata = mem_rdata, else 0).
  - D_CAP → IDLE.
- After P_DONE or D_CAP there is one IDLE cycle before the next grant. This is the minimum turnaround.
- A store with wb_en performs the write in P_ACC, then the writeback read in P_WB.
- Address wrap: addresses are taken modulo 2^AW; no range checking.

Decomposition:
- Shared package dmem_pkg:
  - state enum dmem_state_t;
  - AW and DW defaults;
  - STARVE_LIMIT default.
- One natural sub-module: dmem_arb_starve, the starvation counter plus the IDLE winner decision (pure request/counter logic, about 40 lines).

Test Plan:
- Load, no writeback: mem[5]=0x1234; pipe_req, we=0, addr=5 at T → mem_en at T+1 with addr 5; pipe_done at T+3; pipe_rdata=0x1234; pipe_stall high T..T+2.
- Load with writeback: mem[10]=0xAAAA, mem[14]=0x0E0E; addr=10, wb_en=1, wb_addr=14 → P_ACC addr 10, P_WB addr 14; pipe_done at T+4; pipe_rdata=0xAAAA; pipe_wb_data=0x0E0E.
- Store: we=1, addr=3, wdata=0xBEEF → mem_we=1 at T+1 only; a debug read of addr 3 afterwards returns 0xBEEF with dbg_rvalid one cycle after dbg_gnt.
- Starvation: pipe_req and dbg_req held high continuously → exactly 8 pipeline completions, then dbg_gnt, then pipeline resumes; starve_cnt returns to 0.
- Simultaneous first request (starve_cnt=0) → pipeline granted; dbg_gnt only after pipe_done plus one IDLE cycle.
- Reset asserted during P_WB → next cycle all outputs 0, state IDLE; no pipe_done pulse; a fresh request then completes normally.
